// File: rtl/uart_tx_arbiter.sv
// Purpose : round-robin arbiter sharing one UART transmitter between NUM_SRC byte FIFOs.
// Latency : grant decided at edge N, pop strobe during the following cycle, tx_valid
//           seen from edge N+3; back-to-back bytes in a burst every 3 cycles.
// Backpressure: tx_data/tx_valid are held stable while tx_ready is low; no further pop
//           is issued until the byte in flight is accepted.
// Ports   : clk_sys/rst_n (async active-low), enable, src_empty/src_data/src_rd_en
//           (FIFO read side, data valid the cycle after rd_en), tx_data/tx_valid/tx_ready
//           (transmitter handshake), grant (one-hot owner), busy, src_byte_cnt.
// Option  : define UART_ARB_STATS_EN to build the per-source saturating byte counters;
//           otherwise src_byte_cnt is tied to zero (port list unchanged).
module uart_tx_arbiter #(
   parameter int NUM_SRC   = 2,
   parameter int BURST_MAX = 4,
   parameter int CNT_W     = 16
) (
   input  logic                     clk_sys,
   input  logic                     rst_n,
   input  logic                     enable,
   input  logic [NUM_SRC-1:0]       src_empty,
   input  logic [8*NUM_SRC-1:0]     src_data,
   output logic [NUM_SRC-1:0]       src_rd_en,
   output logic [7:0]               tx_data,
   output logic                     tx_valid,
   input  logic                     tx_ready,
   output logic [NUM_SRC-1:0]       grant,
   output logic                     busy,
   output logic [CNT_W*NUM_SRC-1:0] src_byte_cnt
);

   localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
   localparam logic [NUM_SRC-1:0] ONE = {{(NUM_SRC-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {IDLE, READ, LATCH, SEND} state_t;

   state_t           state;
   logic [IDX_W-1:0] last_grant;
   logic [IDX_W-1:0] winner;
   logic [7:0]       burst_cnt;

   logic [IDX_W-1:0] rr_idx;
   logic             rr_found;
   logic [7:0]       win_data;
   logic [8:0]       burst_next;
   logic             handshake;
   logic             cont;

   // Round-robin search: first non-empty source starting just after last_grant.
   always_comb begin
      int               cand;
      logic [IDX_W-1:0] cidx;
      rr_found = 1'b0;
      rr_idx   = '0;
      cand     = 0;
      cidx     = '0;
      for (int k = 1; k <= NUM_SRC; k++) begin
         cand = int'(last_grant) + k;
         if (cand >= NUM_SRC) cand = cand - NUM_SRC;
         cidx = IDX_W'(cand);
         if (!rr_found && !src_empty[cidx]) begin
            rr_found = 1'b1;
            rr_idx   = cidx;
         end
      end
   end

   // Byte lane of the current owner.
   always_comb begin
      win_data = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (winner == IDX_W'(i)) win_data = src_data[8*i +: 8];
      end
   end

   assign handshake  = tx_valid && tx_ready;
   assign burst_next = {1'b0, burst_cnt} + 9'd1;
   // Continue the burst only if budget remains, the owner still has data and
   // arbitration is still enabled; empty is sampled at least 2 cycles after the last pop.
   assign cont = (burst_next < 9'(BURST_MAX)) && !src_empty[winner] && enable;

   // src_rd_en is registered on the transition into READ, so it is high for
   // exactly the one cycle spent in READ.
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         last_grant <= IDX_W'(NUM_SRC - 1);
         winner     <= '0;
         burst_cnt  <= '0;
         grant      <= '0;
         src_rd_en  <= '0;
         tx_data    <= 8'h00;
         tx_valid   <= 1'b0;
         busy       <= 1'b0;
      end else begin
         src_rd_en <= '0;
         case (state)
            IDLE: begin
               if (enable && rr_found) begin
                  winner     <= rr_idx;
                  last_grant <= rr_idx;
                  grant      <= ONE << rr_idx;
                  src_rd_en  <= ONE << rr_idx;
                  burst_cnt  <= '0;
                  busy       <= 1'b1;
                  state      <= READ;
               end
            end
            READ: begin
               state <= LATCH;
            end
            LATCH: begin
               tx_data  <= win_data;
               tx_valid <= 1'b1;
               state    <= SEND;
            end
            SEND: begin
               if (handshake) begin
                  tx_valid  <= 1'b0;
                  burst_cnt <= burst_cnt + 8'd1;
                  if (cont) begin
                     src_rd_en <= grant;
                     state     <= READ;
                  end else begin
                     grant <= '0;
                     busy  <= 1'b0;
                     state <= IDLE;
                  end
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef UART_ARB_STATS_EN
   logic [CNT_W-1:0] byte_cnt [NUM_SRC];

   // Saturating per-source counters of accepted bytes; cleared only by rst_n.
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_SRC; i++) byte_cnt[i] <= '0;
      end else if (state == SEND && handshake) begin
         for (int i = 0; i < NUM_SRC; i++) begin
            if (grant[i] && (byte_cnt[i] != {CNT_W{1'b1}})) byte_cnt[i] <= byte_cnt[i] + 1'b1;
         end
      end
   end

   for (genvar g = 0; g < NUM_SRC; g++) begin : g_cnt
      assign src_byte_cnt[CNT_W*g +: CNT_W] = byte_cnt[g];
   end
`else
   assign src_byte_cnt = '0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

   localparam int NUM_SRC   = 2;
   localparam int BURST_MAX = 4;
   localparam int CNT_W     = 4;
   localparam int CNT_MAX   = (1 << CNT_W) - 1;

   logic        clk_sys   = 1'b0;
   logic        rst_n     = 1'b1;
   logic        enable    = 1'b0;
   logic [1:0]  src_empty = 2'b11;
   logic [15:0] src_data  = '0;
   logic [1:0]  src_rd_en;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready  = 1'b0;
   logic [1:0]  grant;
   logic        busy;
   logic [7:0]  src_byte_cnt;

   int checks  = 0;
   int errors  = 0;
   int mon_err = 0;
   int cyc     = 0;

   logic [7:0] fq0[$];
   logic [7:0] fq1[$];
   logic [7:0] sc0[$];
   logic [7:0] sc1[$];
   logic [7:0] obs_dat[$];
   logic [1:0] obs_src[$];
   int         hs_cyc[$];
   logic [7:0] exp_dat[$];
   logic [1:0] exp_src[$];
   bit         exp_first[$];
   int         m_last = NUM_SRC - 1;
   int         exp_cnt[2] = '{0, 0};

   uart_tx_arbiter #(.NUM_SRC(NUM_SRC), .BURST_MAX(BURST_MAX), .CNT_W(CNT_W)) dut (
      .clk_sys(clk_sys), .rst_n(rst_n), .enable(enable),
      .src_empty(src_empty), .src_data(src_data), .src_rd_en(src_rd_en),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .grant(grant), .busy(busy), .src_byte_cnt(src_byte_cnt)
   );

   always #5 clk_sys = ~clk_sys;

   // FIFO models (registered read data) plus transaction/invariant monitor.
   always @(posedge clk_sys) begin
      cyc++;
      if ($countones(src_rd_en) > 1) mon_err++;
      if (grant != 2'b00 && $countones(grant) != 1) mon_err++;
      if (src_rd_en[0]) begin
         if (src_empty[0] || fq0.size() == 0) mon_err++;
         else src_data[7:0] <= fq0.pop_front();
      end
      if (src_rd_en[1]) begin
         if (src_empty[1] || fq1.size() == 0) mon_err++;
         else src_data[15:8] <= fq1.pop_front();
      end
      if (rst_n && tx_valid && tx_ready) begin
         obs_dat.push_back(tx_data);
         obs_src.push_back(grant);
         hs_cyc.push_back(cyc);
      end
   end

   always @(negedge clk_sys) begin
      src_empty[0] = (fq0.size() == 0);
      src_empty[1] = (fq1.size() == 0);
   end

   task automatic push(input int s, input logic [7:0] b);
      if (s == 0) begin fq0.push_back(b); sc0.push_back(b); end
      else        begin fq1.push_back(b); sc1.push_back(b); end
   endtask

   // Reference order: grants rotate from last+1 to the first source holding data,
   // each grant takes up to BURST_MAX bytes (all bytes queued up front).
   task automatic plan();
      int s;
      int n;
      while (sc0.size() + sc1.size() > 0) begin
         s = (m_last + 1) % NUM_SRC;
         if ((s == 0 && sc0.size() == 0) || (s == 1 && sc1.size() == 0)) s = 1 - s;
         n = 0;
         while (n < BURST_MAX && ((s == 0) ? sc0.size() : sc1.size()) > 0) begin
            if (s == 0) exp_dat.push_back(sc0.pop_front());
            else        exp_dat.push_back(sc1.pop_front());
            exp_src.push_back((s == 0) ? 2'b01 : 2'b10);
            exp_first.push_back(n == 0);
            if (exp_cnt[s] < CNT_MAX) exp_cnt[s]++;
            n++;
         end
         m_last = s;
      end
   endtask

   task automatic clear_log();
      obs_dat.delete(); obs_src.delete(); hs_cyc.delete();
      exp_dat.delete(); exp_src.delete(); exp_first.delete();
   endtask

   task automatic wait_drain(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk_sys);
         if (obs_dat.size() >= exp_dat.size() && !busy && fq0.size() == 0 && fq1.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      enable = 1'b1;
      tx_ready = 1'b1;
      @(negedge clk_sys);
      checks++;
      if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin
         errors++; $display("FAIL reset_tx: valid=%b data=%h, expected 0/00", tx_valid, tx_data);
      end
      checks++;
      if (src_rd_en !== 2'b00 || grant !== 2'b00 || busy !== 1'b0) begin
         errors++; $display("FAIL reset_ctl: rd_en=%b grant=%b busy=%b, expected 00/00/0", src_rd_en, grant, busy);
      end
      checks++;
      if (src_byte_cnt !== 8'h00) begin
         errors++; $display("FAIL reset_cnt: got %h expected 00", src_byte_cnt);
      end
   endtask

   task automatic test_single_byte();
      bit ok;
      push(0, 8'hA5);
      plan();
      @(negedge clk_sys); @(negedge clk_sys);
      rst_n = 1'b1;
      @(negedge clk_sys);
      checks++;
      if (src_rd_en !== 2'b01 || grant !== 2'b01 || busy !== 1'b1) begin
         errors++; $display("FAIL single_pop: rd_en=%b grant=%b busy=%b, expected 01/01/1", src_rd_en, grant, busy);
      end
      @(negedge clk_sys);
      checks++;
      if (src_rd_en !== 2'b00 || tx_valid !== 1'b0) begin
         errors++; $display("FAIL single_latch: rd_en=%b valid=%b, expected 00/0", src_rd_en, tx_valid);
      end
      @(negedge clk_sys);
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== 8'hA5) begin
         errors++; $display("FAIL single_tx: valid=%b data=%h, expected 1/a5", tx_valid, tx_data);
      end
      @(negedge clk_sys);
      checks++;
      if (tx_valid !== 1'b0 || grant !== 2'b00 || busy !== 1'b0) begin
         errors++; $display("FAIL single_done: valid=%b grant=%b busy=%b, expected 0/00/0", tx_valid, grant, busy);
      end
      wait_drain(ok);
      checks++;
      if (!ok || obs_dat.size() != 1 || obs_dat[0] !== 8'hA5) begin
         errors++; $display("FAIL single_obs: count=%0d, expected one byte a5", obs_dat.size());
      end
      clear_log();
   endtask

   task automatic test_round_robin();
      bit ok;
      for (int i = 0; i < 6; i++) push(0, 8'($urandom));
      for (int i = 0; i < 6; i++) push(1, 8'($urandom));
      plan();
      wait_drain(ok);
      checks++;
      if (!ok || obs_dat.size() != exp_dat.size()) begin
         errors++; $display("FAIL rr_count: got %0d bytes, expected %0d (drained=%b)", obs_dat.size(), exp_dat.size(), ok);
      end
      for (int i = 0; i < exp_dat.size() && i < obs_dat.size(); i++) begin
         checks++;
         if (obs_dat[i] !== exp_dat[i] || obs_src[i] !== exp_src[i]) begin
            errors++; $display("FAIL rr_byte %0d: got %h from %b, expected %h from %b", i, obs_dat[i], obs_src[i], exp_dat[i], exp_src[i]);
         end
         if (i > 0 && !exp_first[i]) begin
            checks++;
            if (hs_cyc[i] - hs_cyc[i-1] != 3) begin
               errors++; $display("FAIL rr_period %0d: got %0d cycles, expected 3", i, hs_cyc[i] - hs_cyc[i-1]);
            end
         end
      end
      checks++;
      if (mon_err != 0) begin
         errors++; $display("FAIL rr_invariants: violations=%0d expected 0", mon_err); mon_err = 0;
      end
      clear_log();
   endtask

   task automatic test_backpressure();
      bit ok;
      logic [7:0] d;
      tx_ready = 1'b0;
      push(1, 8'($urandom)); push(1, 8'($urandom));
      plan();
      ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk_sys);
         ok = tx_valid;
      end
      d = tx_data;
      checks++;
      if (!ok || d !== exp_dat[0]) begin
         errors++; $display("FAIL bp_first: valid=%b data=%h, expected 1/%h", ok, d, exp_dat[0]);
      end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk_sys);
         checks++;
         if (tx_valid !== 1'b1 || tx_data !== d || src_rd_en !== 2'b00) begin
            errors++; $display("FAIL bp_hold %0d: valid=%b data=%h rd_en=%b, expected 1/%h/00", i, tx_valid, tx_data, src_rd_en, d);
         end
      end
      tx_ready = 1'b1;
      @(negedge clk_sys);
      checks++;
      if (obs_dat.size() != 1) begin
         errors++; $display("FAIL bp_accept: got %0d accepted, expected 1", obs_dat.size());
      end
      wait_drain(ok);
      checks++;
      if (!ok || obs_dat.size() != 2 || obs_dat[1] !== exp_dat[1] || obs_src[1] !== exp_src[1]) begin
         errors++; $display("FAIL bp_second: got %0d bytes, expected 2 ending %h", obs_dat.size(), exp_dat[1]);
      end
      clear_log();
   endtask

   task automatic test_enable_drop();
      bit ok;
      for (int i = 0; i < 4; i++) push(0, 8'($urandom));
      plan();
      ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk_sys);
         ok = tx_valid && (obs_dat.size() == 1);
      end
      enable = 1'b0;
      checks++;
      if (!ok) begin
         errors++; $display("FAIL drop_reach: byte 2 not in flight, accepted=%0d expected 1", obs_dat.size());
      end
      for (int i = 0; i < 8; i++) begin
         @(negedge clk_sys);
         checks++;
         if (src_rd_en !== 2'b00) begin
            errors++; $display("FAIL drop_pop %0d: rd_en=%b expected 00", i, src_rd_en);
         end
      end
      checks++;
      if (obs_dat.size() != 2 || busy !== 1'b0 || grant !== 2'b00) begin
         errors++; $display("FAIL drop_idle: accepted=%0d busy=%b grant=%b, expected 2/0/00", obs_dat.size(), busy, grant);
      end
      enable = 1'b1;
      wait_drain(ok);
      checks++;
      if (!ok || obs_dat.size() != exp_dat.size()) begin
         errors++; $display("FAIL drop_count: got %0d expected %0d", obs_dat.size(), exp_dat.size());
      end
      for (int i = 0; i < exp_dat.size() && i < obs_dat.size(); i++) begin
         checks++;
         if (obs_dat[i] !== exp_dat[i] || obs_src[i] !== exp_src[i]) begin
            errors++; $display("FAIL drop_byte %0d: got %h from %b, expected %h from %b", i, obs_dat[i], obs_src[i], exp_dat[i], exp_src[i]);
         end
      end
      clear_log();
   endtask

   task automatic test_reset_mid_send();
      bit ok;
      tx_ready = 1'b0;
      for (int i = 0; i < 3; i++) push(0, 8'($urandom));
      ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk_sys);
         ok = tx_valid;
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (!ok || tx_valid !== 1'b0 || tx_data !== 8'h00 || src_rd_en !== 2'b00 || grant !== 2'b00 || busy !== 1'b0) begin
         errors++; $display("FAIL rst_mid: reached=%b valid=%b data=%h rd_en=%b grant=%b busy=%b, expected 1/0/00/00/00/0",
                            ok, tx_valid, tx_data, src_rd_en, grant, busy);
      end
      checks++;
      if (src_byte_cnt !== 8'h00) begin
         errors++; $display("FAIL rst_mid_cnt: got %h expected 00", src_byte_cnt);
      end
      fq0.delete(); sc0.delete();
      clear_log();
      m_last = NUM_SRC - 1;
      exp_cnt = '{0, 0};
      push(1, 8'h3C);
      plan();
      @(negedge clk_sys); @(negedge clk_sys);
      tx_ready = 1'b1;
      rst_n = 1'b1;
      @(negedge clk_sys);
      checks++;
      if (grant !== 2'b10) begin
         errors++; $display("FAIL rst_regrant: grant=%b expected 10", grant);
      end
      wait_drain(ok);
      checks++;
      if (!ok || obs_dat.size() != 1 || obs_dat[0] !== 8'h3C || obs_src[0] !== 2'b10) begin
         errors++; $display("FAIL rst_byte: got %0d bytes, expected one 3c from src1", obs_dat.size());
      end
      clear_log();
   endtask

   task automatic test_random();
      bit ok;
      for (int r = 0; r < 6; r++) begin
         int n0;
         int n1;
         n0 = $urandom_range(0, 9);
         n1 = $urandom_range(0, 9);
         for (int i = 0; i < n0; i++) push(0, 8'($urandom));
         for (int i = 0; i < n1; i++) push(1, 8'($urandom));
         plan();
         ok = 1'b0;
         for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk_sys);
            tx_ready = ($urandom_range(0, 3) != 0);
            ok = (obs_dat.size() >= exp_dat.size()) && !busy && fq0.size() == 0 && fq1.size() == 0;
         end
         tx_ready = 1'b1;
         checks++;
         if (!ok || obs_dat.size() != exp_dat.size()) begin
            errors++; $display("FAIL rand_count round %0d: got %0d expected %0d", r, obs_dat.size(), exp_dat.size());
         end
         for (int i = 0; i < exp_dat.size() && i < obs_dat.size(); i++) begin
            checks++;
            if (obs_dat[i] !== exp_dat[i] || obs_src[i] !== exp_src[i]) begin
               errors++; $display("FAIL rand_byte r%0d i%0d: got %h from %b, expected %h from %b", r, i, obs_dat[i], obs_src[i], exp_dat[i], exp_src[i]);
            end
         end
         clear_log();
      end
      checks++;
      if (mon_err != 0) begin
         errors++; $display("FAIL rand_invariants: violations=%0d expected 0", mon_err); mon_err = 0;
      end
   endtask

   task automatic test_stats();
      bit ok;
      logic [3:0] e0;
      logic [3:0] e1;
      for (int i = 0; i < 20; i++) push(0, 8'($urandom));
      plan();
      wait_drain(ok);
      checks++;
      if (!ok || obs_dat.size() != 20) begin
         errors++; $display("FAIL stats_count: got %0d bytes expected 20", obs_dat.size());
      end
`ifdef UART_ARB_STATS_EN
      e0 = 4'(exp_cnt[0]);
      e1 = 4'(exp_cnt[1]);
`else
      e0 = 4'h0;
      e1 = 4'h0;
`endif
      checks++;
      if (src_byte_cnt[3:0] !== e0) begin
         errors++; $display("FAIL stats_src0: got %h expected %h", src_byte_cnt[3:0], e0);
      end
      checks++;
      if (src_byte_cnt[7:4] !== e1) begin
         errors++; $display("FAIL stats_src1: got %h expected %h", src_byte_cnt[7:4], e1);
      end
      checks++;
      if (mon_err != 0) begin
         errors++; $display("FAIL stats_invariants: violations=%0d expected 0", mon_err); mon_err = 0;
      end
      clear_log();
   endtask

   initial begin
      #2;
      test_reset();
      test_single_byte();
      test_round_robin();
      test_backpressure();
      test_enable_drop();
      test_reset_mid_send();
      test_random();
      test_stats();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
